uart_rx_frontend: RTL

//  Receives 8N1 serial bytes on the board Rx pin and presents them to the CPU-side I/O buffer.

---
 rtl/uart_rx_frontend_pkg.sv | 9 +
 rtl/uart_baud_counter.sv | 18 +
 rtl/uart_rx_frontend.sv | 90 +++++++++
 3 files changed

// File: rtl/uart_rx_frontend_pkg.sv
// uart_rx_frontend_pkg: shared UART state encodings and frame constants
package uart_rx_frontend_pkg;
  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE, BREAK} state_t;
  function automatic int low_cnt_w(input int clks_per_bit);
    return $clog2(10 * clks_per_bit + 1);
  endfunction
endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: bit-period tick generator, load starts a half-bit wait that absorbs the start-detect cycle
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= W'(CLKS_PER_BIT / 2 - 2);
    else if (en) cnt <= tick ? W'(CLKS_PER_BIT - 1) : cnt - W'(1);
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 8N1 receiver with 2-flop sync, mid-bit sampling, 1-byte valid/ready holding register and error flags
module uart_rx_frontend
  import uart_rx_frontend_pkg::*;
#(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 line_break
);
  localparam int LIM = 10 * CLKS_PER_BIT;
  localparam int LW  = low_cnt_w(CLKS_PER_BIT);
  logic                 s1, s2, tick, load, en, consume;
  state_t               state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic [LW-1:0]        low_cnt;
  assign load    = state == IDLE && !s2;
  assign en      = state inside {START, DATA, STOP};
  assign consume = rx_valid && rx_ready;
  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .en   (en),
    .tick (tick)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1         <= 1'b1;
      s2         <= 1'b1;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      low_cnt    <= '0;
      line_break <= 1'b0;
    end else begin
      s1        <= rx;
      s2        <= s1;
      frame_err <= 1'b0;
      if (consume) rx_valid <= 1'b0;
      if (s2) begin
        low_cnt    <= '0;
        line_break <= 1'b0;
      end else if (low_cnt != LW'(LIM)) begin
        low_cnt    <= low_cnt + LW'(1);
        line_break <= low_cnt == LW'(LIM - 1);
      end
      case (state)
        IDLE: if (!s2) begin
          state   <= START;
          bit_cnt <= '0;
        end
        START: if (tick) begin
          state   <= s2 ? IDLE : DATA;
          bit_cnt <= '0;
        end
        DATA: if (tick) begin
          shreg   <= {s2, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state <= STOP;
        end
        STOP: if (tick) begin
          state     <= s2 ? DONE : BREAK;
          frame_err <= !s2;
        end
        DONE: begin
          state <= IDLE;
          if (!rx_valid || consume) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
          end else overrun <= 1'b1;
        end
        BREAK: if (s2) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
